// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and address-split helpers
// for the line-cached fetch stage and its queue.
package ifetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    MISS  = 1'b1
  } fstate_e;

  // Queue entry layout at the default 32-bit address width.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fq_entry_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w,
                               input int line_words,
                               input int num_lines);
    return addr_w - offset_w(line_words) - index_w(num_lines);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO between fetch and decode,
// power-of-two depth, flush empties it in one cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  slot_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign dout  = slot_q[rd_q];

  // pointer and occupancy update; flush wins over push/pop
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // pointer/count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push && !flush) slot_q[wr_q] <= din;
  end

endmodule

// File: rtl/ins_fetch_q.sv
// ins_fetch_q: PC, direct-mapped line cache with line refill,
// and a fetch queue toward decode; MEM redirects flush it.
module ins_fetch_q
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              LINE_WORDS = 4,
  parameter int              NUM_LINES  = 16,
  parameter int              FQ_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_valid,
  input  logic [LINE_WORDS*32-1:0] mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_ins,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pc4,
  input  logic                     out_ready,
  output logic [31:0]              miss_cnt
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int WSEL_W   = OFFSET_W - 2;
  localparam int QW       = ADDR_W + 32;
  localparam int CW       = $clog2(FQ_DEPTH) + 1;

  fstate_e             state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic                pend_q, pend_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic [NUM_LINES-1:0] vld_q, vld_d;

  logic [TAG_W-1:0]           tag_mem  [NUM_LINES];
  logic [LINE_WORDS*32-1:0]   data_mem [NUM_LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WSEL_W-1:0]  wsel;
  logic [31:0]        word;
  logic               hit;
  logic [ADDR_W-1:0]  tgt;
  logic               push, pop, fill;
  logic               q_empty, q_full;
  logic [CW-1:0]      q_cnt;
  logic [QW-1:0]      q_din, q_dout;
  logic               unused_bits;

  assign idx  = pc_q[OFFSET_W +: INDEX_W];
  assign tag  = pc_q[ADDR_W-1 -: TAG_W];
  assign wsel = pc_q[2 +: WSEL_W];
  assign word = data_mem[idx][{wsel, 5'b0} +: 32];
  assign hit  = vld_q[idx] && (tag_mem[idx] == tag);
  assign tgt  = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign q_din = {pc_q, word};
  assign pop   = !q_empty && out_ready;

  assign out_valid = !q_empty;
  assign out_pc    = q_empty ? '0 : q_dout[QW-1:32];
  assign out_ins   = q_empty ? '0 : q_dout[31:0];
  assign out_pc4   = q_empty ? '0 : q_dout[QW-1:32] + ADDR_W'(4);
  assign miss_cnt  = miss_cnt_q;

  assign unused_bits = ^{q_cnt, redirect_pc[1:0]};

  // next-state: lookup/push in FETCH, refill and pending redirect in MISS
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    miss_cnt_d = miss_cnt_q;
    vld_d      = vld_q;
    push       = 1'b0;
    fill       = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = tgt;
        end else if (!hit) begin
          state_d = MISS;
        end else if (!q_full) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_W'(4);
        end
      end
      MISS: begin
        mem_req  = 1'b1;
        mem_addr = {pc_q[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
        if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = tgt;
        end
        if (mem_valid) begin
          fill       = 1'b1;
          vld_d[idx] = 1'b1;
          state_d    = FETCH;
          pend_d     = 1'b0;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
          if (redirect_valid) pc_d = tgt;
          else if (pend_q)    pc_d = pend_pc_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      miss_cnt_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      miss_cnt_q <= miss_cnt_d;
      vld_q      <= vld_d;
    end
  end

  // tag/data line write on refill completion
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_rdata;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     (QW)
  ) u_fq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full),
    .count (q_cnt)
  );

endmodule

// File: tb/tb_ins_fetch_q.sv
// tb_ins_fetch_q: scoreboard bench for the line-cached fetch queue
// with a delayed-response memory model.
module tb_ins_fetch_q;
  import ifetch_pkg::*;

  localparam int TMO = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_valid;
  logic [127:0] mem_rdata;
  logic         out_valid;
  logic [31:0]  out_ins;
  logic [31:0]  out_pc;
  logic [31:0]  out_pc4;
  logic         out_ready;
  logic [31:0]  miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fq_entry_t sb[$];

  logic mem_auto  = 1'b0;
  logic rsp_pulse = 1'b0;
  int   rsp_wait  = 0;

  ins_fetch_q dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ins        (out_ins),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .out_ready      (out_ready),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_at(input logic [31:0] a);
    return 32'h11 + (a >> 2);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'b0};
    for (int i = 0; i < 4; i++)
      l[i*32 +: 32] = ins_at(base + 32'(4*i));
    return l;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_seq(input logic [31:0] a, input int n);
    fq_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc  = a + 32'(4*i);
      e.ins = ins_at(e.pc);
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(mem_req && mem_addr == a) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", 64'(n < TMO), 64'd1);
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    int n = 0;
    while (miss_cnt != v && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_wait", 64'(n < TMO), 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", 64'(n < TMO), 64'd1);
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    while (sb.size() != 0 && n < TMO) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_wait", 64'(n < TMO), 64'd1);
  endtask

  // memory model: answer a refill request three cycles later
  always @(posedge clk) begin
    #2;
    if (rsp_pulse) begin
      mem_valid = 1'b0;
      rsp_pulse = 1'b0;
      rsp_wait  = 0;
    end else if (mem_auto && mem_req) begin
      rsp_wait++;
      if (rsp_wait == 3) begin
        mem_valid = 1'b1;
        mem_rdata = line_of(mem_addr);
        rsp_pulse = 1'b1;
      end
    end else begin
      rsp_wait = 0;
    end
  end

  // consume accepted entries against the scoreboard
  always @(negedge clk) begin
    fq_entry_t e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_ins", 64'(out_ins), 64'(e.ins));
        chk("out_pc4", 64'(out_pc4), 64'(e.pc + 32'd4));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_valid      = 1'b0;
    mem_rdata      = '0;
    out_ready      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_cnt", 64'(miss_cnt), 64'd0);
    chk("rst_ins", 64'(out_ins), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_pc4", 64'(out_pc4), 64'd0);

    // cold start
    cyc(1);
    rst       = 1'b0;
    out_ready = 1'b1;
    mem_auto  = 1'b1;
    exp_seq(32'h0, 4);
    wait_req(32'h0);
    chk("cold_cnt0", 64'(miss_cnt), 64'd0);
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("cold_back2back", 64'(out_valid), 64'd1);
    end
    cyc(1);
    out_ready = 1'b0;
    wait_req(32'h10);
    chk("cold_cnt1", 64'(miss_cnt), 64'd1);
    wait_cnt(32'd2);
    cyc(1);
    mem_auto = 1'b0;

    // backpressure: queue fills with line 0x10, then 0x20 misses
    cyc(10);
    @(negedge clk);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_head", 64'(out_pc), 64'h10);
    chk("bp_req", 64'(mem_req), 64'd1);
    chk("bp_addr", 64'(mem_addr), 64'h20);

    // redirect during refill, later one overwrites the target
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdm_flush", 64'(out_valid), 64'd0);
    chk("rdm_req", 64'(mem_req), 64'd1);
    chk("rdm_addr", 64'(mem_addr), 64'h20);
    cyc(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hB;
    cyc(1);
    redirect_valid = 1'b0;
    exp_seq(32'h8, 10);
    out_ready = 1'b1;
    mem_auto  = 1'b1;
    wait_sb_empty();
    chk("rdm_cnt", 64'(miss_cnt), 64'd3);
    cyc(1);
    out_ready = 1'b0;
    mem_auto  = 1'b0;

    // redirect to 0 from the 0x30 miss, then fill and hold
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc(1);
    redirect_valid = 1'b0;
    mem_auto       = 1'b1;
    wait_cnt(32'd4);
    cyc(1);
    mem_auto = 1'b0;
    cyc(10);
    @(negedge clk);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_head", 64'(out_pc), 64'h0);
    chk("full_ins", 64'(out_ins), 64'h11);
    chk("full_noreq", 64'(mem_req), 64'd0);

    // pop one, then redirect on a hit with three entries held
    exp_seq(32'h0, 1);
    cyc(1);
    out_ready = 1'b1;
    cyc(1);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdh_gap", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("rdh_valid", 64'(out_valid), 64'd1);
    chk("rdh_pc", 64'(out_pc), 64'h4);
    chk("rdh_ins", 64'(out_ins), 64'h12);
    chk("rdh_pc4", 64'(out_pc4), 64'h8);
    exp_seq(32'h4, 7);
    cyc(1);
    out_ready = 1'b1;
    wait_sb_empty();
    cyc(1);
    out_ready = 1'b0;

    // conflict miss on index 0
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc(1);
    redirect_valid = 1'b0;
    mem_auto       = 1'b1;
    out_ready      = 1'b1;
    exp_seq(32'h100, 4);
    wait_req(32'h100);
    wait_cnt(32'd5);
    cyc(1);
    mem_auto = 1'b0;
    wait_sb_empty();
    cyc(1);
    out_ready = 1'b0;
    chk("cf_cnt5", 64'(miss_cnt), 64'd5);
    wait_req(32'h110);
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc(1);
    redirect_valid = 1'b0;
    mem_auto       = 1'b1;
    wait_cnt(32'd6);
    cyc(1);
    mem_auto = 1'b0;
    wait_req(32'h0);
    chk("cf_cnt6", 64'(miss_cnt), 64'd6);

    // reset in MISS with a coincident mem_valid
    cyc(1);
    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = '1;
    cyc(1);
    rst       = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rm_req", 64'(mem_req), 64'd0);
    chk("rm_cnt", 64'(miss_cnt), 64'd0);
    chk("rm_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("rm_remiss", 64'(mem_req), 64'd1);
    chk("rm_addr", 64'(mem_addr), 64'h0);
    exp_seq(32'h0, 4);
    cyc(1);
    mem_auto  = 1'b1;
    out_ready = 1'b1;
    wait_sb_empty();
    cyc(1);
    out_ready = 1'b0;
    mem_auto  = 1'b0;
    chk("rm_cnt1", 64'(miss_cnt), 64'd1);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
